raw_bayer_demosaic: RTL

Parametrised Bayer RAW-to-RGB converter. It is the successor to the fixed 10-bit, RGGB-only converter in the camera display path. It runs in the pixel/VGA clock domain and accepts a RAW pixel stream framed by frame-valid and line-valid. It holds one previous line in an internal line RAM, reconstructs RGB from a 2x2 window, and outputs RGB with aligned coordinates, runtime-selectable Bayer phase, a grey passthrough mode and line-overflow detection.

---
 rtl/raw_bayer_demosaic_pkg.sv | 38 +++
 rtl/raw_bayer_demosaic_line_ram.sv | 31 +++
 rtl/raw_bayer_demosaic.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/raw_bayer_demosaic_pkg.sv
// raw_pkg: shared constants and helpers for the Bayer RAW-to-RGB converter.
//   PAT_*      : Bayer phase codes as presented on i_pattern
//   MODE_*     : i_mode codes
//   win_pos_e  : 2x2 window position; bit1 = row flip, bit0 = column flip vs P11
//   r_pos()    : window position holding the R sample for a pattern and pixel parity
package raw_pkg;

    localparam logic [1:0] PAT_RGGB = 2'd0;
    localparam logic [1:0] PAT_GRBG = 2'd1;
    localparam logic [1:0] PAT_GBRG = 2'd2;
    localparam logic [1:0] PAT_BGGR = 2'd3;

    localparam logic MODE_DEMOSAIC = 1'b0;
    localparam logic MODE_GREY     = 1'b1;

    typedef enum logic [1:0] {
        WIN_P11 = 2'b00,
        WIN_P10 = 2'b01,
        WIN_P01 = 2'b10,
        WIN_P00 = 2'b11
    } win_pos_e;

    // yx = {row parity, col parity} of P11. The R sample sits where the
    // absolute parity matches the R site, i.e. at flip = site XOR yx.
    function automatic win_pos_e r_pos(input logic [1:0] pattern, input logic [1:0] yx);
        logic [1:0] r_site;
        r_site = 2'b00;
        case (pattern)
            PAT_RGGB: r_site = 2'b00;
            PAT_GRBG: r_site = 2'b01;
            PAT_GBRG: r_site = 2'b10;
            PAT_BGGR: r_site = 2'b11;
            default:  r_site = 2'b00;
        endcase
        return win_pos_e'(r_site ^ yx);
    endfunction

endpackage

// File: rtl/raw_bayer_demosaic_line_ram.sv
// raw_line_ram: single-port line buffer, read-before-write, 1-cycle read latency.
//   VGA_CLK : clock
//   en      : access enable (read, and write when we=1)
//   we      : write enable
//   addr    : column address
//   wdata   : pixel written at addr
//   rdata   : previous content of addr, valid the cycle after en
module raw_line_ram #(
    parameter int DW    = 10,
    parameter int MAX_W = 2048,
    localparam int AW   = (MAX_W > 1) ? $clog2(MAX_W) : 1
) (
    input  logic          VGA_CLK,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [MAX_W];

    always_ff @(posedge VGA_CLK) begin
        if (en) begin
            rdata <= mem[addr];
            if (we)
                mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/raw_bayer_demosaic.sv
// raw_bayer_demosaic: Bayer RAW stream to RGB, 2x2 window, 2-cycle latency.
//   VGA_CLK, RST_N        : clock, synchronous active-low reset
//   i_fval, i_lval        : frame / line valid framing
//   i_data                : RAW pixel (DW bits)
//   i_pattern, i_mode     : Bayer phase and grey passthrough, shadowed in blanking
//   o_red/o_green/o_blue  : colour channels (OW bits), zero when o_dval=0
//   o_dval, o_x, o_y      : output valid and pixel coordinates
//   o_ovf                 : sticky line-too-long flag, cleared in blanking
module raw_bayer_demosaic
    import raw_pkg::*;
#(
    parameter int DW    = 10,
    parameter int OW    = 8,
    parameter int MAX_W = 2048,
    parameter int XW    = 11
) (
    input  logic          VGA_CLK,
    input  logic          RST_N,
    input  logic          i_fval,
    input  logic          i_lval,
    input  logic [DW-1:0] i_data,
    input  logic [1:0]    i_pattern,
    input  logic          i_mode,
    output logic [OW-1:0] o_red,
    output logic [OW-1:0] o_green,
    output logic [OW-1:0] o_blue,
    output logic          o_dval,
    output logic [XW-1:0] o_x,
    output logic [XW-1:0] o_y,
    output logic          o_ovf
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(MAX_W - 1);

    // Left-justify into DW+OW bits and keep the top OW: truncates when
    // OW<=DW, zero-pads when OW>DW.
    function automatic logic [OW-1:0] to_ow(input logic [DW-1:0] v);
        logic [DW+OW-1:0] t;
        t = {v, {OW{1'b0}}};
        return t[DW+OW-1 -: OW];
    endfunction

    logic [XW-1:0] src_x, src_y;
    logic          line_act;
    logic          sat;
    logic [1:0]    pat_s;
    logic          mode_s;

    logic pix, at_last, ram_we;
    logic [DW-1:0] ram_q;

    assign pix     = i_fval & i_lval;
    assign at_last = (src_x == X_LAST);
    // Once the last column has been written this line, further pixels
    // must not overwrite it.
    assign ram_we  = pix & ~(at_last & sat);

    always_ff @(posedge VGA_CLK) begin
        if (!RST_N || !i_fval) begin
            src_x    <= '0;
            src_y    <= '0;
            line_act <= 1'b0;
            sat      <= 1'b0;
            pat_s    <= i_pattern;
            mode_s   <= i_mode;
        end else if (i_lval) begin
            if (!at_last)
                src_x <= src_x + 1'b1;
            sat      <= sat | at_last;
            line_act <= 1'b1;
        end else begin
            src_x    <= '0;
            sat      <= 1'b0;
            line_act <= 1'b0;
            if (line_act)
                src_y <= src_y + 1'b1;
        end
    end

    raw_line_ram #(
        .DW    (DW),
        .MAX_W (MAX_W)
    ) u_line_ram (
        .VGA_CLK (VGA_CLK),
        .en      (pix),
        .we      (ram_we),
        .addr    (src_x[AW-1:0]),
        .wdata   (i_data),
        .rdata   (ram_q)
    );

    // Stage 1: aligned with the RAM read. cur1/prev1 hold the current and
    // previous pixel of this row; prevq holds the RAM read of the previous
    // column, giving P00 next to ram_q (P01).
    logic          v1;
    logic [XW-1:0] x1, y1;
    logic [DW-1:0] cur1, prev1, prevq;
    logic [1:0]    pat1;
    logic          mode1;

    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            v1    <= 1'b0;
            x1    <= '0;
            y1    <= '0;
            cur1  <= '0;
            prev1 <= '0;
            prevq <= '0;
            pat1  <= '0;
            mode1 <= 1'b0;
        end else begin
            v1 <= pix;
            if (pix) begin
                cur1  <= i_data;
                prev1 <= cur1;
                prevq <= ram_q;
                x1    <= src_x;
                y1    <= src_y;
                pat1  <= pat_s;
                mode1 <= mode_s;
            end
        end
    end

    logic [DW-1:0] p11, p10, p01, p00;
    logic [DW-1:0] win [4];
    win_pos_e      rpos;
    logic [DW-1:0] r_raw, b_raw;
    logic [DW:0]   gsum;
    logic [OW-1:0] r_c, g_c, b_c;

    always_comb begin
        p11 = cur1;
        p10 = (x1 == '0) ? cur1 : prev1;
        p01 = (y1 == '0) ? p11 : ram_q;
        p00 = (y1 == '0) ? p10 : ((x1 == '0) ? ram_q : prevq);

        win[WIN_P11] = p11;
        win[WIN_P10] = p10;
        win[WIN_P01] = p01;
        win[WIN_P00] = p00;

        rpos  = r_pos(pat1, {y1[0], x1[0]});
        r_raw = win[rpos];
        b_raw = win[rpos ^ 2'b11];
        gsum  = {1'b0, win[rpos ^ 2'b01]} + {1'b0, win[rpos ^ 2'b10]};

        case (mode1)
            MODE_DEMOSAIC: begin
                r_c = to_ow(r_raw);
                g_c = to_ow(gsum[DW:1]);
                b_c = to_ow(b_raw);
            end
            default: begin
                r_c = to_ow(p11);
                g_c = to_ow(p11);
                b_c = to_ow(p11);
            end
        endcase
    end

    // Stage 2: output register.
    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
            o_dval  <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_ovf   <= 1'b0;
        end else begin
            o_dval <= v1;
            if (v1) begin
                o_red   <= r_c;
                o_green <= g_c;
                o_blue  <= b_c;
                o_x     <= x1;
                o_y     <= y1;
            end else begin
                o_red   <= '0;
                o_green <= '0;
                o_blue  <= '0;
            end
            if (!i_fval)
                o_ovf <= 1'b0;
            else if (pix && at_last && sat)
                o_ovf <= 1'b1;
        end
    end

endmodule
